reaction_test_ctrl: RTL and testbench

Trial sequencer for the reaction tester. On a start request it captures the 13-bit random delay (ms) from the LFSR random-number generator and waits that many milliseconds. It then lights the go LED and measures the user's reaction in milliseconds. It also flags false starts (reacting before the LED) and timeouts (no reaction), and drives the result and display-side status outputs.

---
 rtl/reaction_test_ctrl.sv | 148 ++++++++++++++
 tb/tb_reaction_test_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reaction_test_ctrl.sv
// rtl/reaction_test_ctrl.sv - reaction tester trial sequencer
//
// Runs one reaction trial per start pulse: waits a random number of
// milliseconds, lights the go LED, then measures the reaction time in ms.
// Flags false starts (react before the LED) and timeouts (no react).
//
// Parameters:
//   TICKS_PER_MS  clk cycles per millisecond (>= 2)
//   TIMEOUT_MS    longest reaction measured in GO (< 16384)
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   i_start         single-cycle start pulse
//   i_react         single-cycle reaction-button pulse
//   i_random_num    random delay in ms, captured on start
//   o_led           go light (GO)
//   o_busy          trial running (DELAY or GO)
//   o_result_valid  result available (DONE)
//   o_reaction_ms   last measured reaction time, ms
//   o_false_start   false start flagged (FOUL)
//   o_timeout       last trial ended by timeout (held in DONE)
//   o_best_ms       best reaction time so far
//
// Build option:
//   REACTION_BEST_TIME_EN  defined: o_best_ms tracks the smallest reaction;
//                          undefined: o_best_ms is tied to 14'h3FFF.

module reaction_test_ctrl #(
   parameter int TICKS_PER_MS = 50000,
   parameter int TIMEOUT_MS   = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_react,
   input  logic [12:0] i_random_num,
   output logic        o_led,
   output logic        o_busy,
   output logic        o_result_valid,
   output logic [13:0] o_reaction_ms,
   output logic        o_false_start,
   output logic        o_timeout,
   output logic [13:0] o_best_ms
);

   localparam int              TW          = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [TW-1:0]   TICK_LAST   = TW'(TICKS_PER_MS - 1);
   localparam logic [13:0]     TIMEOUT_VAL = 14'(TIMEOUT_MS);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DELAY = 3'd1;
   localparam logic [2:0] S_GO    = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_FOUL  = 3'd4;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [TW-1:0] tick_cnt;
   logic [13:0]   ms_cnt;
   logic [12:0]   delay_reg;
   logic          tick;
   logic          delay_done;
   logic          go_timeout;
   logic          can_start;

   assign tick = (tick_cnt == TICK_LAST);

   // 13-bit compare: a delay of 0 wraps to 8191 and therefore lasts 8192 ms.
   assign delay_done = tick && (ms_cnt[12:0] == (delay_reg - 13'd1));
   assign go_timeout = tick && ((ms_cnt + 14'd1) == TIMEOUT_VAL);
   assign can_start  = (state == S_IDLE) || (state == S_DONE) || (state == S_FOUL);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_start) state_nxt = S_DELAY;
         // React wins over delay expiry in the same cycle.
         S_DELAY: if (i_react) state_nxt = S_FOUL;
                  else if (delay_done) state_nxt = S_GO;
         S_GO:    if (i_react || go_timeout) state_nxt = S_DONE;
         S_DONE:  if (i_start) state_nxt = S_DELAY;
         S_FOUL:  if (i_start) state_nxt = S_DELAY;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         tick_cnt      <= '0;
         ms_cnt        <= 14'd0;
         delay_reg     <= 13'd0;
         o_reaction_ms <= 14'd0;
         o_timeout     <= 1'b0;
      end else begin
         state <= state_nxt;

         // Both counters restart on every state entry so each phase is
         // timed from its own first cycle.
         if (state_nxt != state) begin
            tick_cnt <= '0;
            ms_cnt   <= 14'd0;
         end else if ((state == S_DELAY) || (state == S_GO)) begin
            tick_cnt <= tick ? '0 : (tick_cnt + TW'(1));
            if (tick) ms_cnt <= ms_cnt + 14'd1;
         end

         if (can_start && i_start) delay_reg <= i_random_num;

         // A react on the timeout tick still counts, with the pre-increment value.
         if (state == S_GO) begin
            if (i_react) begin
               o_reaction_ms <= ms_cnt;
               o_timeout     <= 1'b0;
            end else if (go_timeout) begin
               o_reaction_ms <= TIMEOUT_VAL;
               o_timeout     <= 1'b1;
            end
         end else if ((state == S_DONE) && i_start) begin
            o_timeout <= 1'b0;
         end
      end
   end

   assign o_led          = (state == S_GO);
   assign o_busy         = (state == S_DELAY) || (state == S_GO);
   assign o_result_valid = (state == S_DONE);
   assign o_false_start  = (state == S_FOUL);

`ifdef REACTION_BEST_TIME_EN
   logic [13:0] best_ms;

   // Only genuine reactions update the best; FOUL and timeouts never reach here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_ms <= 14'h3FFF;
      end else if ((state == S_GO) && i_react && (ms_cnt < best_ms)) begin
         best_ms <= ms_cnt;
      end
   end

   assign o_best_ms = best_ms;
`else
   assign o_best_ms = 14'h3FFF;
`endif

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// tb/tb_reaction_test_ctrl.sv - table-driven bench for reaction_test_ctrl

module tb_reaction_test_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_react = 1'b0;
   logic [12:0] i_random_num = 13'd0;
   logic        o_led;
   logic        o_busy;
   logic        o_result_valid;
   logic [13:0] o_reaction_ms;
   logic        o_false_start;
   logic        o_timeout;
   logic [13:0] o_best_ms;

   reaction_test_ctrl #(.TICKS_PER_MS(4), .TIMEOUT_MS(20)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_start        (i_start),
      .i_react        (i_react),
      .i_random_num   (i_random_num),
      .o_led          (o_led),
      .o_busy         (o_busy),
      .o_result_valid (o_result_valid),
      .o_reaction_ms  (o_reaction_ms),
      .o_false_start  (o_false_start),
      .o_timeout      (o_timeout),
      .o_best_ms      (o_best_ms)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          gap;
      bit          rst;
      bit          start;
      bit          react;
      logic [12:0] rnd;
      logic [4:0]  flags;
      logic [13:0] ms;
      logic [13:0] best;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   localparam logic [13:0] NB = 14'h3FFF;

   function automatic logic [13:0] bst(input logic [13:0] v);
`ifdef REACTION_BEST_TIME_EN
      return v;
`else
      return NB;
`endif
   endfunction

   function automatic void add(input string name, input int gap, input bit r, input bit s,
                               input bit re, input logic [12:0] rnd, input logic [4:0] fl,
                               input logic [13:0] ms, input logic [13:0] best);
      vec_t v;
      v.name = name; v.gap = gap; v.rst = r; v.start = s; v.react = re; v.rnd = rnd;
      v.flags = fl; v.ms = ms; v.best = best;
      vecs.push_back(v);
   endfunction

   localparam logic [4:0] F_IDLE  = 5'b00000;
   localparam logic [4:0] F_DELAY = 5'b01000;
   localparam logic [4:0] F_GO    = 5'b11000;
   localparam logic [4:0] F_DONE  = 5'b00100;
   localparam logic [4:0] F_TOUT  = 5'b00101;
   localparam logic [4:0] F_FOUL  = 5'b00010;

   initial begin
      logic [4:0] act_fl;

      add("reset",          0,    1, 0, 0, 13'd0,   F_IDLE,  14'd0,  NB);
      add("idle_react_ign", 0,    0, 0, 1, 13'd0,   F_IDLE,  14'd0,  NB);
      add("t1_start",       0,    0, 1, 0, 13'd500, F_DELAY, 14'd0,  NB);
      add("t1_pre_led",     1998, 0, 0, 0, 13'd0,   F_DELAY, 14'd0,  NB);
      add("t1_led",         0,    0, 0, 0, 13'd0,   F_GO,    14'd0,  NB);
      add("t1_react",       28,   0, 0, 1, 13'd0,   F_DONE,  14'd7,  bst(14'd7));
      add("done_react_ign", 0,    0, 0, 1, 13'd0,   F_DONE,  14'd7,  bst(14'd7));
      add("t2_start",       0,    0, 1, 0, 13'd600, F_DELAY, 14'd7,  bst(14'd7));
      add("t2_foul",        98,   0, 0, 1, 13'd0,   F_FOUL,  14'd7,  bst(14'd7));
      add("t3_start",       0,    0, 1, 0, 13'd500, F_DELAY, 14'd7,  bst(14'd7));
      add("t3_led",         1999, 0, 0, 0, 13'd0,   F_GO,    14'd7,  bst(14'd7));
      add("t3_pre_tout",    78,   0, 0, 0, 13'd0,   F_GO,    14'd7,  bst(14'd7));
      add("t3_timeout",     0,    0, 0, 0, 13'd0,   F_TOUT,  14'd20, bst(14'd7));
      add("t3_restart",     0,    0, 1, 0, 13'd500, F_DELAY, 14'd20, bst(14'd7));
      add("t4_delay_coll",  1999, 0, 0, 1, 13'd0,   F_FOUL,  14'd20, bst(14'd7));
      add("t4_start",       0,    0, 1, 0, 13'd500, F_DELAY, 14'd20, bst(14'd7));
      add("t4_led",         1999, 0, 0, 0, 13'd0,   F_GO,    14'd20, bst(14'd7));
      add("t4_pre_tout",    78,   0, 0, 0, 13'd0,   F_GO,    14'd20, bst(14'd7));
      add("t4_go_coll",     0,    0, 0, 1, 13'd0,   F_DONE,  14'd19, bst(14'd7));
      add("t5_start",       0,    0, 1, 0, 13'd500, F_DELAY, 14'd19, bst(14'd7));
      add("t5_delay_start", 10,   0, 1, 0, 13'd100, F_DELAY, 14'd19, bst(14'd7));
      add("t5_led",         1988, 0, 0, 0, 13'd0,   F_GO,    14'd19, bst(14'd7));
      add("t5_go_start",    5,    0, 1, 0, 13'd100, F_GO,    14'd19, bst(14'd7));
      add("t5_rst_mid_go",  0,    1, 0, 0, 13'd0,   F_IDLE,  14'd0,  NB);
      add("t5_post_rst",    0,    0, 0, 0, 13'd0,   F_IDLE,  14'd0,  NB);
      add("t6a_start",      0,    0, 1, 0, 13'd3,   F_DELAY, 14'd0,  NB);
      add("t6a_led",        11,   0, 0, 0, 13'd0,   F_GO,    14'd0,  NB);
      add("t6a_react9",     36,   0, 0, 1, 13'd0,   F_DONE,  14'd9,  bst(14'd9));
      add("t6b_start",      0,    0, 1, 0, 13'd3,   F_DELAY, 14'd9,  bst(14'd9));
      add("t6b_led",        11,   0, 0, 0, 13'd0,   F_GO,    14'd9,  bst(14'd9));
      add("t6b_react5",     20,   0, 0, 1, 13'd0,   F_DONE,  14'd5,  bst(14'd5));
      add("t6c_start",      0,    0, 1, 0, 13'd3,   F_DELAY, 14'd5,  bst(14'd5));
      add("t6c_led",        11,   0, 0, 0, 13'd0,   F_GO,    14'd5,  bst(14'd5));
      add("t6c_timeout",    79,   0, 0, 0, 13'd0,   F_TOUT,  14'd20, bst(14'd5));
      add("t6d_start",      0,    0, 1, 0, 13'd3,   F_DELAY, 14'd20, bst(14'd5));
      add("t6d_led",        11,   0, 0, 0, 13'd0,   F_GO,    14'd20, bst(14'd5));
      add("t6d_react7",     28,   0, 0, 1, 13'd0,   F_DONE,  14'd7,  bst(14'd5));

      @(posedge clk);
      #1;
      n_checks++;
      if (o_led === 1'b0 && o_busy === 1'b0 && o_result_valid === 1'b0 &&
          o_false_start === 1'b0 && o_timeout === 1'b0 &&
          o_reaction_ms === 14'd0 && o_best_ms === NB) begin
         n_pass++;
      end else begin
         $display("FAIL reset_state: led=%b busy=%b valid=%b fs=%b to=%b ms=%0d best=%h",
                  o_led, o_busy, o_result_valid, o_false_start, o_timeout,
                  o_reaction_ms, o_best_ms);
      end

      foreach (vecs[i]) begin
         repeat (vecs[i].gap) begin
            @(negedge clk);
            rst = 1'b0; i_start = 1'b0; i_react = 1'b0; i_random_num = 13'd0;
         end
         @(negedge clk);
         rst = vecs[i].rst; i_start = vecs[i].start; i_react = vecs[i].react;
         i_random_num = vecs[i].rnd;
         @(posedge clk);
         #1;
         act_fl = {o_led, o_busy, o_result_valid, o_false_start, o_timeout};
         n_checks++;
         if (act_fl === vecs[i].flags && o_reaction_ms === vecs[i].ms &&
             o_best_ms === vecs[i].best) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got flags(led,busy,valid,fs,to)=%b ms=%0d best=%h, expected flags=%b ms=%0d best=%h",
                     vecs[i].name, act_fl, o_reaction_ms, o_best_ms,
                     vecs[i].flags, vecs[i].ms, vecs[i].best);
         end
      end

      @(negedge clk);
      rst = 1'b0; i_start = 1'b0; i_react = 1'b0;
      if (n_pass != n_checks) begin
         $display("FAIL summary: %0d of %0d checks failed", n_checks - n_pass, n_checks);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
